dev_cmd_tx: RTL

Command-frame UART transmitter for the simulated-device link. It consumes the 8-bit command byte assembled by the device top level (`{2'b10, destroy_beacon, place_beacon, moving_state}`) and serialises it as 8N1 UART on `txd` toward the simulator. A frame is sent whenever the command changes, plus an optional periodic keep-alive resend. Malformed commands are blocked so the simulator never sees a byte without the `2'b10` header.

---
 rtl/dev_cmd_tx_pkg.sv | 23 ++
 rtl/dev_cmd_tx_if.sv | 22 ++
 rtl/dev_cmd_tx_baud_tick.sv | 34 +++
 rtl/dev_cmd_tx.sv | 139 +++++++++++++
 4 files changed

// File: rtl/dev_cmd_tx_pkg.sv
// Shared types and constants for the device command-frame UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dev_cmd_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Every command byte the simulator accepts carries this header in bits [7:6].
    localparam logic [1:0] CMD_HDR = 2'b10;

    // 100 MHz / 9600 baud.
    localparam int DEF_CLKS_PER_BIT = 10417;

    function automatic logic hdr_ok(input logic [7:0] c);
        return c[7:6] == CMD_HDR;
    endfunction

endpackage

// File: rtl/dev_cmd_tx_if.sv
// Command-in / UART-out bundle between the device top level and the transmitter.
// Latency: n/a (wires only).
// Backpressure: none on this bundle; enable gates new frames only.
interface dev_cmd_tx_if;
    logic [7:0] cmd;
    logic       enable;
    logic       txd;
    logic       busy;
    logic       frame_done;
    logic       hdr_err;
    logic [7:0] last_sent;

    modport master (
        output cmd, enable,
        input  txd, busy, frame_done, hdr_err, last_sent
    );

    modport slave (
        input  cmd, enable,
        output txd, busy, frame_done, hdr_err, last_sent
    );
endinterface

// File: rtl/dev_cmd_tx_baud_tick.sv
// Modulo-CLKS_PER_BIT bit-period counter with synchronous restart.
// Latency: tick high in the last cycle of each bit period; pre_tick one cycle earlier.
// Backpressure: none; free-runs unless restarted.
module baud_tick
    import dev_cmd_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic restart,
    output logic tick,
    output logic pre_tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count;

    // Count 0..CLKS_PER_BIT-1 and wrap; restart realigns to a fresh bit period.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (restart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick     = (count == LAST);
    assign pre_tick = (count == PRE);
endmodule

// File: rtl/dev_cmd_tx.sv
// 8N1 UART sender of device command bytes: on change, optional keep-alive resend (DEV_CMD_KEEPALIVE_EN).
// Latency: txd falls on the edge that samples a changed cmd; frame is 10*CLKS_PER_BIT cycles, >=1 idle cycle between frames.
// Backpressure: cmd changes during a frame are coalesced (latest wins); enable=0 blocks new frames only.
module dev_cmd_tx
    import dev_cmd_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEF_CLKS_PER_BIT,
    parameter int KEEPALIVE_CYC = 10_000_000
) (
    input  logic           sys_clk,
    input  logic           rst,
    dev_cmd_tx_if.slave    bus
);
    tx_state_t  state, state_nxt;
    logic [7:0] shift, shift_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic [7:0] last_sent, last_sent_nxt;
    logic       hdr_err, hdr_err_nxt;
    logic       txd, txd_nxt;
    logic       busy, frame_done;
    logic       restart, frame_start;
    logic       tick, pre_tick;
    logic       ka_expired;

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .restart  (restart),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

`ifdef DEV_CMD_KEEPALIVE_EN
    localparam int KW = $clog2(KEEPALIVE_CYC + 1);
    localparam logic [KW-1:0] KA_LAST = KW'(KEEPALIVE_CYC - 1);
    logic [KW-1:0] ka_cnt;

    // Idle-time counter; saturates so a resend stays pending through a bad-header spell.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            ka_cnt <= '0;
        end else if (frame_start || !bus.enable || state != IDLE) begin
            ka_cnt <= '0;
        end else if (ka_cnt != KA_LAST) begin
            ka_cnt <= ka_cnt + KW'(1);
        end
    end

    assign ka_expired = (ka_cnt == KA_LAST);
`else
    logic unused_keepalive;
    assign unused_keepalive = (KEEPALIVE_CYC != 0);
    assign ka_expired       = 1'b0;
`endif

    // Next-state, datapath and registered-output precompute.
    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift;
        bit_idx_nxt   = bit_idx;
        last_sent_nxt = last_sent;
        hdr_err_nxt   = hdr_err;
        restart       = 1'b0;
        frame_start   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable) begin
                    if (!hdr_ok(bus.cmd)) begin
                        hdr_err_nxt = 1'b1;
                    end else if (bus.cmd != last_sent) begin
                        shift_nxt     = bus.cmd;
                        last_sent_nxt = bus.cmd;
                        frame_start   = 1'b1;
                    end else if (ka_expired) begin
                        shift_nxt   = last_sent;
                        frame_start = 1'b1;
                    end
                end
                if (frame_start) begin
                    state_nxt   = START;
                    restart     = 1'b1;
                    bit_idx_nxt = 3'd0;
                end
            end
            START: begin
                if (tick) state_nxt = DATA;
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        shift_nxt   = {1'b0, shift[7:1]};
                    end
                end
            end
            STOP: begin
                if (tick) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = shift_nxt[0];
            default: txd_nxt = 1'b1;
        endcase
    end

    // State, datapath and output registers; reset forces the line idle at once.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shift      <= 8'h00;
            bit_idx    <= 3'd0;
            last_sent  <= 8'h00;
            hdr_err    <= 1'b0;
            txd        <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift      <= shift_nxt;
            bit_idx    <= bit_idx_nxt;
            last_sent  <= last_sent_nxt;
            hdr_err    <= hdr_err_nxt;
            txd        <= txd_nxt;
            busy       <= (state_nxt != IDLE);
            frame_done <= (state == STOP) && pre_tick;
        end
    end

    assign bus.txd        = txd;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
    assign bus.hdr_err    = hdr_err;
    assign bus.last_sent  = last_sent;
endmodule
